// File: rtl/param_bank_arbiter.sv
// Shared single-port memory bank with a round-robin arbiter across N_CORES requesters.
// Optional BANK_ARB_VGA_PORT_EN adds an independent read-only video port.
module param_bank_arbiter #(
   parameter int N_CORES     = 16,
   parameter int DATA_W      = 8,
   parameter int BANK_ADDR_W = 8,
   parameter int BANK_SEL_W  = 4,
   parameter int BANK_ID     = 0
) (
   input  logic                                       clock,
   input  logic                                       reset_n,
   input  logic [N_CORES-1:0]                         read,
   input  logic [N_CORES-1:0]                         write,
   input  logic [N_CORES*(BANK_SEL_W+BANK_ADDR_W)-1:0] addr_in,
   input  logic [N_CORES*DATA_W-1:0]                  data_in,
`ifdef BANK_ARB_VGA_PORT_EN
   input  logic [BANK_ADDR_W-1:0]                     addr_vga,
   output logic [DATA_W-1:0]                          data_vga,
`endif
   output logic [N_CORES*DATA_W-1:0]                  data_out,
   output logic [N_CORES-1:0]                         finish
);

   localparam int ADDR_W = BANK_SEL_W + BANK_ADDR_W;
   localparam int PTR_W  = $clog2(N_CORES);
   localparam int DEPTH  = 2 ** BANK_ADDR_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [PTR_W-1:0]          ptr_q, ptr_d;
   logic [PTR_W-1:0]          grant_q, grant_d;
   logic                      wr_q, wr_d;
   logic [BANK_ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]         wdata_q, wdata_d;
   logic [N_CORES-1:0]        finish_q, finish_d;
   logic [N_CORES*DATA_W-1:0] dout_q, dout_d;

   logic [N_CORES-1:0] eligible;
   logic               any_elig;
   logic [PTR_W-1:0]   pick;
   logic [DATA_W-1:0]  rdata;
   int                 idx;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         eligible[i] = (read[i] | write[i]) &&
            (addr_in[i*ADDR_W+BANK_ADDR_W +: BANK_SEL_W] == BANK_SEL_W'(BANK_ID));
      end
   end

   // Walk offsets high to low so the closest eligible core at/after ptr wins.
   always_comb begin
      pick     = '0;
      any_elig = 1'b0;
      idx      = 0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_CORES) idx = idx - N_CORES;
         if (eligible[idx]) begin
            pick     = PTR_W'(idx);
            any_elig = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      finish_d = finish_q;
      dout_d   = dout_q;
      rdata    = mem_q[addr_q];
      unique case (state_q)
         S_IDLE: begin
            if (any_elig) begin
               grant_d = pick;
               wr_d    = write[pick];
               addr_d  = addr_in[pick*ADDR_W +: BANK_ADDR_W];
               wdata_d = data_in[pick*DATA_W +: DATA_W];
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            finish_d          = '0;
            finish_d[grant_q] = 1'b1;
            dout_d            = '0;
            if (!wr_q) dout_d[grant_q*DATA_W +: DATA_W] = rdata;
            state_d = S_DONE;
         end
         S_DONE: begin
            finish_d = '0;
            dout_d   = '0;
            ptr_d    = (grant_q == PTR_W'(N_CORES - 1)) ? '0 : grant_q + 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         finish_q <= '0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         finish_q <= finish_d;
         dout_q   <= dout_d;
      end
   end

   // Storage is deliberately not reset; only the committed write path touches it.
   always_ff @(posedge clock) begin
      if (state_q == S_ACCESS && wr_q) mem_q[addr_q] <= wdata_q;
   end

`ifdef BANK_ARB_VGA_PORT_EN
   logic [DATA_W-1:0] data_vga_q, data_vga_d;

   always_comb data_vga_d = mem_q[addr_vga];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) data_vga_q <= '0;
      else          data_vga_q <= data_vga_d;
   end

   assign data_vga = data_vga_q;
`endif

   assign finish   = finish_q;
   assign data_out = dout_q;

endmodule
